// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state encoding and parameter checks for the MAC processing element
package pe_pkg;

  typedef enum logic [1:0] {
    PE_IDLE  = 2'd0,
    PE_ACCUM = 2'd1,
    PE_HOLD  = 2'd2
  } pe_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  function automatic bit acc_w_legal(input int data_w, input int acc_w);
    return acc_w >= 2 * data_w;
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// rtl/pe_sat_add.sv - combinational accumulator adder with signed/unsigned overflow and optional clamp
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             signed_mode,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] raw;
  logic           s_ovf;
  logic           u_ovf;

  assign raw = {1'b0, a} + {1'b0, b};
  // Unsigned addends are zero-extended products, so carry-out is the only way to overflow.
  assign u_ovf = raw[ACC_W];
  assign s_ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

  always_comb begin
    ovf = signed_mode ? s_ovf : u_ovf;
    sum = raw[ACC_W-1:0];
    if (SAT && ovf) begin
      if (!signed_mode) begin
        sum = '1;
      end else if (a[ACC_W-1]) begin
        sum = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/pe_mac_stream.sv
// rtl/pe_mac_stream.sv - systolic MAC processing element with programmable dot-product length
module pe_mac_stream
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  k_len,
  input  logic              signed_mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              fwd_valid,
  output logic              busy,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [ACC_W-1:0]  c_out,
  output logic              ovf
);

  if (!acc_w_legal(DATA_W, ACC_W)) begin : g_acc_w_illegal
    $error("pe_mac_stream: ACC_W must be at least 2*DATA_W");
  end

  logic [1:0]              state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n, cnt_inc, klen_q, klen_n, klen_eff;
  logic                    mode_q, mode_n, mode_eff;
  logic [ACC_W-1:0]        acc, acc_n, add_base, sum;
  logic                    ovf_n, add_ovf;
  logic                    do_start, accepting, beat;
  logic signed [ACC_W-1:0] a_sx, b_sx;
  logic [ACC_W-1:0]        a_x, b_x, prod;

  // In HOLD a start only takes effect together with the result handshake.
  assign do_start  = start && ((state != ST_HOLD) || c_ready);
  assign mode_eff  = do_start ? signed_mode : mode_q;
  assign klen_eff  = do_start ? k_len : klen_q;
  assign accepting = do_start ? (k_len != '0) : (state == ST_ACCUM);
  assign beat      = in_valid && accepting;

  // The true product fits in 2*DATA_W bits, so the low ACC_W bits of the wide product are its extension.
  assign a_sx = ACC_W'($signed(a_in));
  assign b_sx = ACC_W'($signed(b_in));
  assign a_x  = mode_eff ? a_sx : ACC_W'(a_in);
  assign b_x  = mode_eff ? b_sx : ACC_W'(b_in);
  assign prod = a_x * b_x;

  assign add_base = do_start ? '0 : acc;
  assign cnt_inc  = (do_start ? '0 : cnt) + CNT_W'(1);

  pe_sat_add #(
    .ACC_W (ACC_W),
    .SAT   (SAT != 0)
  ) u_sat_add (
    .a           (add_base),
    .b           (prod),
    .signed_mode (mode_eff),
    .sum         (sum),
    .ovf         (add_ovf)
  );

  always_comb begin
    state_n = state;
    acc_n   = acc;
    ovf_n   = ovf;
    cnt_n   = cnt;
    klen_n  = klen_q;
    mode_n  = mode_q;
    if (do_start) begin
      acc_n   = '0;
      ovf_n   = 1'b0;
      cnt_n   = '0;
      klen_n  = k_len;
      mode_n  = signed_mode;
      state_n = (k_len == '0) ? ST_HOLD : ST_ACCUM;
    end else if (state == ST_HOLD && c_ready) begin
      state_n = ST_IDLE;
    end
    if (beat) begin
      acc_n = sum;
      ovf_n = ovf_n | add_ovf;
      cnt_n = cnt_inc;
      if (cnt_inc == klen_eff) state_n = ST_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      klen_q    <= '0;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      c_valid   <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      fwd_valid <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      ovf       <= ovf_n;
      cnt       <= cnt_n;
      klen_q    <= klen_n;
      mode_q    <= mode_n;
      busy      <= (state_n == ST_ACCUM);
      c_valid   <= (state_n == ST_HOLD);
      a_out     <= a_in;
      b_out     <= b_in;
      fwd_valid <= in_valid;
    end
  end

  assign c_out = acc;

endmodule

// File: tb/tb_pe_mac_stream.sv
// tb/tb_pe_mac_stream.sv - randomized self-checking bench for pe_mac_stream
module tb_pe_mac_stream;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] k_len;
  logic       signed_mode;
  logic       in_valid;
  logic [7:0] a_in, b_in;
  logic       c_ready;

  logic [7:0]  a_out, b_out, a_out_s16, b_out_s16, a_out_w16, b_out_w16;
  logic        fwd_valid, fwd_valid_s16, fwd_valid_w16;
  logic        busy, busy_s16, busy_w16;
  logic        c_valid, c_valid_s16, c_valid_w16;
  logic        ovf, ovf_s16, ovf_w16;
  logic [31:0] c_out;
  logic [15:0] c_out_s16, c_out_w16;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  longint     exp_main;

  pe_mac_stream #(.DATA_W(8), .ACC_W(32), .CNT_W(8), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out),
    .fwd_valid(fwd_valid), .busy(busy), .c_valid(c_valid), .c_ready(c_ready),
    .c_out(c_out), .ovf(ovf)
  );

  pe_mac_stream #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SAT(1)) dut_s16 (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .a_in(a_in), .b_in(b_in), .a_out(a_out_s16), .b_out(b_out_s16),
    .fwd_valid(fwd_valid_s16), .busy(busy_s16), .c_valid(c_valid_s16), .c_ready(c_ready),
    .c_out(c_out_s16), .ovf(ovf_s16)
  );

  pe_mac_stream #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SAT(0)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .a_in(a_in), .b_in(b_in), .a_out(a_out_w16), .b_out(b_out_w16),
    .fwd_valid(fwd_valid_w16), .busy(busy_w16), .c_valid(c_valid_w16), .c_ready(c_ready),
    .c_out(c_out_w16), .ovf(ovf_w16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: running sum with per-addition clamp or modular wrap into a w-bit range.
  function automatic void mdl(input longint p[$], input int w, input bit sat, input bit sm,
                              output longint r, output bit o);
    longint one = 1;
    longint lo, hi, s;
    lo = sm ? -(one <<< (w - 1)) : 0;
    hi = sm ? (one <<< (w - 1)) - 1 : (one <<< w) - 1;
    s = 0;
    o = 0;
    foreach (p[i]) begin
      s = s + p[i];
      if (s > hi || s < lo) begin
        o = 1;
        if (sat) s = (s > hi) ? hi : lo;
        else begin
          s = s & ((one <<< w) - 1);
          if (sm && s > hi) s = s - (one <<< w);
        end
      end
    end
    r = s;
  endfunction

  // Forwarding reference: outputs equal the inputs seen at the previous edge, or 0 under reset.
  bit         fwd_armed = 0;
  logic [7:0] fa, fb;
  logic       fv, fr;
  always @(posedge clk) begin
    fa = a_in;
    fb = b_in;
    fv = in_valid;
    fr = rst_n;
    fwd_armed = 1;
  end
  always @(negedge clk) begin
    if (fwd_armed && !done) begin
      check_eq("fwd_a", a_out, fr ? fa : 8'h00);
      check_eq("fwd_b", b_out, fr ? fb : 8'h00);
      check_eq("fwd_v", fwd_valid, fr ? fv : 1'b0);
    end
  end

  task automatic release_result(input int rdy_delay, input longint e32);
    for (int i = 0; i < rdy_delay; i++) begin
      tick();
      check_eq("hold_valid", c_valid, 1);
      check_eq("hold_c_out", c_out, e32 & 64'hFFFF_FFFF);
    end
    c_ready = 1'b1;
    tick();
    c_ready  = 1'b0;
    in_valid = 1'b0;
    check_eq("valid_drop", c_valid, 0);
  endtask

  task automatic run_dot(input int klen, input bit mode, input logic [7:0] av[$],
                         input logic [7:0] bv[$], input int gap_pct, input int rdy_delay,
                         input bit hold_open);
    longint prods[$];
    longint e32, es16, ew16;
    bit     o32, os16, ow16;
    int     idx = 0;
    int     guard = 0;
    for (int i = 0; i < klen; i++)
      prods.push_back(mode ? longint'($signed(av[i])) * longint'($signed(bv[i]))
                           : longint'(av[i]) * longint'(bv[i]));
    mdl(prods, 32, 1'b1, mode, e32, o32);
    mdl(prods, 16, 1'b1, mode, es16, os16);
    mdl(prods, 16, 1'b0, mode, ew16, ow16);
    start       = 1'b1;
    k_len       = 8'(klen);
    signed_mode = mode;
    c_ready     = 1'b0;
    if (klen == 0) begin
      in_valid = 1'b1;
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
      tick();
      start = 1'b0;
    end else begin
      while (idx < klen && guard < 500) begin
        if (gap_pct == 0 || $urandom_range(99) >= gap_pct) begin
          in_valid = 1'b1;
          a_in     = av[idx];
          b_in     = bv[idx];
          idx++;
        end else begin
          in_valid = 1'b0;
          a_in     = 8'($urandom);
          b_in     = 8'($urandom);
        end
        tick();
        guard++;
        if (guard == 1) check_eq("busy_after_start", busy, idx < klen);
        start = 1'b0;
      end
      check_eq("beat_budget", idx, klen);
    end
    // Stray beats while the result is held must not disturb it.
    in_valid = 1'($urandom_range(1));
    a_in     = 8'($urandom);
    b_in     = 8'($urandom);
    check_eq("c_valid_rise", c_valid, 1);
    check_eq("busy_in_hold", busy, 0);
    check_eq("c_out32", c_out, e32 & 64'hFFFF_FFFF);
    check_eq("ovf32", ovf, o32);
    check_eq("c_out_s16", c_out_s16, es16 & 64'hFFFF);
    check_eq("ovf_s16", ovf_s16, os16);
    check_eq("c_out_w16", c_out_w16, ew16 & 64'hFFFF);
    check_eq("ovf_w16", ovf_w16, ow16);
    exp_main = e32;
    if (!hold_open) release_result(rdy_delay, e32);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = 8'd0; signed_mode = 1'b0;
    in_valid = 1'b1; a_in = 8'hA5; b_in = 8'h5A; c_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_c_valid", c_valid, 0);
    check_eq("rst_c_out", c_out, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();

    qa.delete(); qb.delete();
    qa.push_back(8'd1); qa.push_back(8'd2); qa.push_back(8'd3);
    qb.push_back(8'd4); qb.push_back(8'd5); qb.push_back(8'd6);
    run_dot(3, 1'b0, qa, qb, 0, 0, 1'b1);
    check_eq("tp_u3_sum", c_out, 32);
    check_eq("tp_u3_ovf", ovf, 0);
    release_result(0, 32);

    qa.delete(); qb.delete();
    qa.push_back(8'hFD); qb.push_back(8'h07);
    run_dot(1, 1'b1, qa, qb, 0, 0, 1'b1);
    check_eq("tp_s1_sum", c_out, 32'hFFFF_FFEB);
    release_result(1, 32'hFFFF_FFEB);
    run_dot(1, 1'b0, qa, qb, 0, 0, 1'b1);
    check_eq("tp_u1_sum", c_out, 1771);
    release_result(0, 1771);

    qa.delete(); qb.delete();
    qa.push_back(8'hFF); qa.push_back(8'hFF);
    qb.push_back(8'hFF); qb.push_back(8'hFF);
    run_dot(2, 1'b0, qa, qb, 0, 0, 1'b1);
    check_eq("tp_sat16_sum", c_out_s16, 16'hFFFF);
    check_eq("tp_sat16_ovf", ovf_s16, 1);
    check_eq("tp_wrap16_sum", c_out_w16, 16'hFC02);
    check_eq("tp_wrap16_ovf", ovf_w16, 1);
    check_eq("tp_wide_sum", c_out, 130050);
    release_result(0, 130050);

    // Back-pressure: start without c_ready is ignored, then handshake plus restart with no bubble.
    qa.delete(); qb.delete();
    qa.push_back(8'd9); qa.push_back(8'd11);
    qb.push_back(8'd3); qb.push_back(8'd7);
    run_dot(2, 1'b0, qa, qb, 30, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; k_len = 8'd1; in_valid = 1'b1;
      a_in = 8'($urandom); b_in = 8'($urandom);
      tick();
      check_eq("bp_valid", c_valid, 1);
      check_eq("bp_c_out", c_out, 104);
      check_eq("bp_busy", busy, 0);
    end
    start = 1'b1; k_len = 8'd1; signed_mode = 1'b0; in_valid = 1'b1;
    a_in = 8'd2; b_in = 8'd2; c_ready = 1'b1;
    tick();
    start = 1'b0; c_ready = 1'b0; in_valid = 1'b0;
    check_eq("bp_restart_valid", c_valid, 1);
    check_eq("bp_restart_c_out", c_out, 4);
    release_result(0, 4);

    qa.delete(); qb.delete();
    run_dot(0, 1'b1, qa, qb, 0, 0, 1'b1);
    check_eq("k0_c_out", c_out, 0);
    check_eq("k0_ovf", ovf, 0);
    release_result(2, 0);

    // Reset during the second of three beats, then a clean run.
    start = 1'b1; k_len = 8'd3; signed_mode = 1'b0; in_valid = 1'b1; a_in = 8'd10; b_in = 8'd10;
    tick();
    start = 1'b0; a_in = 8'd20; b_in = 8'd20; rst_n = 1'b0;
    tick();
    check_eq("midrst_c_out", c_out, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_valid", c_valid, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    qa.delete(); qb.delete();
    qa.push_back(8'd2); qa.push_back(8'd3); qa.push_back(8'd4);
    qb.push_back(8'd5); qb.push_back(8'd6); qb.push_back(8'd7);
    run_dot(3, 1'b0, qa, qb, 0, 0, 1'b1);
    check_eq("postrst_sum", c_out, 56);
    release_result(0, 56);

    for (int r = 0; r < 30; r++) begin
      int  kl;
      bit  md;
      kl = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(6, 1));
      md = 1'($urandom_range(1));
      qa.delete(); qb.delete();
      for (int i = 0; i < kl; i++) begin
        qa.push_back(8'($urandom));
        qb.push_back(8'($urandom));
      end
      run_dot(kl, md, qa, qb, 30, int'($urandom_range(3)), 1'b0);
      if ($urandom_range(1) == 1) tick();
    end

    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
